// File: rtl/text_overlay.sv
// rtl/text_overlay.sv - double-buffered scaled text overlay renderer (option: TEXT_OVERLAY_TRANSPARENT_EN)
module text_overlay #(
    parameter int MAX_CHARS  = 16,
    parameter int NUM_W      = 5,
    parameter int CHAR_W     = 15,
    parameter int CHAR_H     = 17,
    parameter int PITCH      = 18,
    parameter int SCALE_LOG2 = 0,
    parameter int ROM_AW     = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [10:0]            hcount,
    input  logic [9:0]             vcount,
    input  logic [10:0]            x,
    input  logic [9:0]             y,
    input  logic [23:0]            fg_color,
    input  logic [23:0]            bg_color,
    input  logic                   load,
    input  logic [MAX_CHARS*8-1:0] string_in,
    input  logic [NUM_W-1:0]       numchar_in,
    output logic                   pending,
    output logic [ROM_AW-1:0]      rom_addr,
    input  logic [CHAR_W-1:0]      rom_data,
    output logic [23:0]            pixel,
    output logic                   text_on
);

    localparam int STR_W  = MAX_CHARS * 8;
    localparam int IDX_W  = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
    localparam int CELL_W = PITCH << SCALE_LOG2;
    localparam int SUB_W  = $clog2(CELL_W + 1);
    localparam int BIT_W  = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
    localparam int ROW_W  = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;
    localparam int BOX_H  = CHAR_H << SCALE_LOG2;

    localparam logic [SUB_W-1:0]  SUB_LAST   = SUB_W'(CELL_W - 1);
    localparam logic [NUM_W-1:0]  NUM_MAX    = NUM_W'(MAX_CHARS);
    localparam logic [ROM_AW-1:0] SPACE_BASE = ROM_AW'(26 * CHAR_H);

    // string buffers
    logic [STR_W-1:0] shadow_str;
    logic [STR_W-1:0] active_str;
    logic [NUM_W-1:0] shadow_num;
    logic [NUM_W-1:0] active_num;

    logic             frame_start;
    logic [NUM_W-1:0] num_clamped;

    // stage 0: column counters and row
    logic             run;
    logic [SUB_W-1:0] sub;
    logic [IDX_W-1:0] char_idx;
    logic [ROW_W-1:0] row_q;
    logic [23:0]      fg_q0;
    logic [23:0]      bg_q0;

    logic [10:0]      y_end;
    logic [9:0]       row_off;
    logic             row_hit;
    logic [ROW_W-1:0] row_sel;
    logic             start;
    logic             cell_end;
    logic             last_char;

    // stage 1: ROM address and bit index
    logic [7:0]        char_code;
    logic [ROM_AW-1:0] glyph_base;
    logic [SUB_W-1:0]  glyph_col;
    logic              col_in;
    logic [BIT_W-1:0]  bit_sel;
    logic              valid_q1;
    logic              col_in_q1;
    logic [BIT_W-1:0]  bit_q1;
    logic [23:0]       fg_q1;
    logic [23:0]       bg_q1;

    // stage 2: aligned with the ROM output register
    logic              valid_q2;
    logic              col_in_q2;
    logic [BIT_W-1:0]  bit_q2;
    logic [23:0]       fg_q2;
    logic [23:0]       bg_q2;
    logic              rom_bit;

    assign frame_start = (hcount == 11'd0) && (vcount == 10'd0);
    assign num_clamped = (numchar_in > NUM_MAX) ? NUM_MAX : numchar_in;

    // shadow capture on load, commit to active at frame start; a same-cycle load keeps pending set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_str <= '0;
            shadow_num <= '0;
            active_str <= '0;
            active_num <= '0;
            pending    <= 1'b0;
        end else begin
            if (frame_start && pending) begin
                active_str <= shadow_str;
                active_num <= shadow_num;
                pending    <= 1'b0;
            end
            if (load) begin
                shadow_str <= string_in;
                shadow_num <= num_clamped;
                pending    <= 1'b1;
            end
        end
    end

    // row window, start condition and end-of-cell/end-of-string detection
    always_comb begin
        y_end     = {1'b0, y} + 11'(BOX_H);
        row_hit   = ({1'b0, vcount} >= {1'b0, y}) && ({1'b0, vcount} < y_end);
        row_off   = vcount - y;
        row_sel   = ROW_W'(row_off >> SCALE_LOG2);
        start     = (hcount == x) && row_hit && (active_num != '0);
        cell_end  = (sub == SUB_LAST);
        last_char = (NUM_W'(char_idx) == (active_num - 1'b1));
    end

    // stage 0: character/sub-pixel counters run from the box start to the last cell
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run      <= 1'b0;
            sub      <= '0;
            char_idx <= '0;
            row_q    <= '0;
            fg_q0    <= '0;
            bg_q0    <= '0;
        end else begin
            row_q <= row_sel;
            fg_q0 <= fg_color;
            bg_q0 <= bg_color;
            if (start) begin
                run      <= 1'b1;
                sub      <= '0;
                char_idx <= '0;
            end else if (run) begin
                if (cell_end) begin
                    sub <= '0;
                    if (last_char) begin
                        run <= 1'b0;
                    end else begin
                        char_idx <= char_idx + 1'b1;
                    end
                end else begin
                    sub <= sub + 1'b1;
                end
            end
        end
    end

    // character lookup, glyph base address and bit position within the ROM word
    always_comb begin
        char_code = 8'(active_str >> (8 * (MAX_CHARS - 1 - int'(char_idx))));
        if ((char_code >= 8'h41) && (char_code <= 8'h5A)) begin
            glyph_base = ROM_AW'(char_code - 8'h41) * ROM_AW'(CHAR_H);
        end else begin
            glyph_base = SPACE_BASE;
        end
        glyph_col = sub >> SCALE_LOG2;
        col_in    = (glyph_col < SUB_W'(CHAR_W));
        bit_sel   = BIT_W'(SUB_W'(CHAR_W - 1) - glyph_col);
    end

    // stage 1: register ROM address and the column information that rides alongside
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_addr  <= '0;
            valid_q1  <= 1'b0;
            col_in_q1 <= 1'b0;
            bit_q1    <= '0;
            fg_q1     <= '0;
            bg_q1     <= '0;
        end else begin
            rom_addr  <= glyph_base + ROM_AW'(row_q);
            valid_q1  <= run;
            col_in_q1 <= col_in;
            bit_q1    <= bit_sel;
            fg_q1     <= fg_q0;
            bg_q1     <= bg_q0;
        end
    end

    // stage 2: delay column information while the font ROM registers its word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q2  <= 1'b0;
            col_in_q2 <= 1'b0;
            bit_q2    <= '0;
            fg_q2     <= '0;
            bg_q2     <= '0;
        end else begin
            valid_q2  <= valid_q1;
            col_in_q2 <= col_in_q1;
            bit_q2    <= bit_q1;
            fg_q2     <= fg_q1;
            bg_q2     <= bg_q1;
        end
    end

    assign rom_bit = rom_data[bit_q2];

    // stage 3: colour selection; gap columns and zero bits are background
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel   <= 24'h000000;
            text_on <= 1'b0;
        end else begin
`ifdef TEXT_OVERLAY_TRANSPARENT_EN
            if (valid_q2 && col_in_q2 && rom_bit) begin
                pixel   <= fg_q2;
                text_on <= 1'b1;
            end else begin
                pixel   <= 24'h000000;
                text_on <= 1'b0;
            end
`else
            if (valid_q2) begin
                pixel   <= (col_in_q2 && rom_bit) ? fg_q2 : bg_q2;
                text_on <= 1'b1;
            end else begin
                pixel   <= 24'h000000;
                text_on <= 1'b0;
            end
`endif
        end
    end

endmodule
